// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM status, word type and the memory arbiter state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    // A word finishes on ACCESS, or on ERROR with its data discarded.
    function automatic logic ram_done(input ramstate_t s);
        return (s == ACCESS) || (s == ERROR);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that saturates at LIMIT; clear takes priority over increment.
module sat_counter #(
    parameter int LIMIT = 8,
    parameter int W     = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != W'(LIMIT))) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: the owner keeps the RAM until it drops its request,
// data side wins arbitration unless the icache has starved.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  word_t       iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  word_t       daddr,
    input  word_t       dstore,
    output logic        iwait,
    output logic        dwait,
    output word_t       iload,
    output word_t       dload,
    output logic        ramREN,
    output logic        ramWEN,
    output word_t       ramaddr,
    output word_t       ramstore,
    input  word_t       ramload,
    input  logic [1:0]  ramstate,
    output logic [1:0]  grant,
    output logic        ram_err
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t       state_q, state_d;
    logic             ram_err_q, ram_err_d;
    logic [CNT_W-1:0] starve_cnt;
    ramstate_t        rs;
    logic             dreq, starved, arb_pt, done;
    logic             cnt_inc, cnt_clr;

    assign rs      = ramstate_t'(ramstate);
    assign dreq    = dREN | dWEN;
    assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign done    = ram_done(rs);
    assign arb_pt  = (state_q == IDLE)
                   || ((state_q == IGNT) && !iREN)
                   || ((state_q == DGNT) && !dreq);

    assign cnt_inc = iREN && (state_q != IGNT);
    assign cnt_clr = !iREN || (state_d == IGNT);

    sat_counter #(
        .LIMIT (STARVE_LIMIT),
        .W     (CNT_W)
    ) u_starve (
        .clk_i (CLK),
        .rst_i (nRST),
        .inc_i (cnt_inc),
        .clr_i (cnt_clr),
        .cnt_o (starve_cnt)
    );

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q   <= IDLE;
            ram_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ram_err_q <= ram_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ram_err_d = ram_err_q | (rs == ERROR);
        if (arb_pt) begin
            if (dreq && !(iREN && starved)) begin
                state_d = DGNT;
            end else if (iREN) begin
                state_d = IGNT;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        grant    = 2'b00;
        iwait    = 1'b1;
        dwait    = 1'b1;
        iload    = '0;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        unique case (state_q)
            IGNT: begin
                grant   = 2'b01;
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iwait   = !done;
                iload   = (rs == ERROR) ? '0 : ramload;
            end
            DGNT: begin
                grant    = 2'b10;
                ramREN   = dREN & !dWEN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !done;
                dload    = (rs == ERROR) ? '0 : ramload;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign ram_err = ram_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table plus multi-cycle sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    word_t       iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, ram_err;
    word_t       iload, dload, ramaddr, ramstore;
    logic [1:0]  grant;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.STARVE_LIMIT(8)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .iwait    (iwait),
        .dwait    (dwait),
        .iload    (iload),
        .dload    (dload),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate),
        .grant    (grant),
        .ram_err  (ram_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ien, den, dwen;
        logic [31:0] ia, da, ds, rl;
        logic [1:0]  rs;
        logic [1:0]  g;
        logic        iw, dw, ren, wen, err;
        logic [31:0] ra, rst_, il, dl;
    } vec_t;

    vec_t tv[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0;
        ramload = 0; ramstate = 2'd0;
    endtask

    initial begin
        // ramstore is not defined while the icache owns the RAM: x = skip
        tv[0] = '{0,0,0, 32'h0,32'h0,32'h0,32'h0, 2'd0,
                  2'b00, 1,1,0,0,0, 32'h0,32'h0,32'h0,32'h0};
        tv[1] = '{1,0,0, 32'h100,32'h0,32'h0,32'h1111, 2'd0,
                  2'b00, 1,1,0,0,0, 32'h0,32'h0,32'h0,32'h0};
        tv[2] = '{1,0,0, 32'h100,32'h0,32'h0,32'h1111, 2'd1,
                  2'b01, 1,1,1,0,0, 32'h100,32'hx,32'h1111,32'h0};
        tv[3] = '{1,1,0, 32'h100,32'h200,32'h0,32'hAAAA5555, 2'd2,
                  2'b01, 0,1,1,0,0, 32'h100,32'hx,32'hAAAA5555,32'h0};
        tv[4] = '{0,1,0, 32'h104,32'h200,32'h55,32'h0, 2'd0,
                  2'b01, 1,1,1,0,0, 32'h104,32'hx,32'h0,32'h0};
        tv[5] = '{0,1,0, 32'h104,32'h200,32'h55,32'h12345678, 2'd2,
                  2'b10, 1,0,1,0,0, 32'h200,32'h55,32'h0,32'h12345678};
        tv[6] = '{0,1,1, 32'h104,32'h204,32'h99,32'hFFFF, 2'd3,
                  2'b10, 1,0,0,1,0, 32'h204,32'h99,32'h0,32'h0};
        tv[7] = '{0,0,0, 32'h104,32'h204,32'h99,32'h0, 2'd0,
                  2'b10, 1,1,0,0,1, 32'h204,32'h99,32'h0,32'h0};
        tv[8] = '{0,0,0, 32'h0,32'h0,32'h0,32'h3333, 2'd2,
                  2'b00, 1,1,0,0,1, 32'h0,32'h0,32'h0,32'h0};

        // reset held with both requesters active
        idle_inputs();
        nRST = 1;
        iREN = 1; dREN = 1; ramstate = 2'd1; ramload = 32'h5555;
        step(); step();
        chk("rst.grant", 32'(grant), 32'h0);
        chk("rst.iwait", 32'(iwait), 32'h1);
        chk("rst.dwait", 32'(dwait), 32'h1);
        chk("rst.ren", 32'(ramREN), 32'h0);
        chk("rst.wen", 32'(ramWEN), 32'h0);
        chk("rst.addr", ramaddr, 32'h0);
        chk("rst.store", ramstore, 32'h0);
        chk("rst.iload", iload, 32'h0);
        chk("rst.dload", dload, 32'h0);
        chk("rst.err", 32'(ram_err), 32'h0);
        chk("rst.cnt", 32'(dut.starve_cnt), 32'h0);
        nRST = 0;
        step();
        chk("s1.grant", 32'(grant), 32'h2);
        chk("s1.dwait_b0", 32'(dwait), 32'h1);
        chk("s1.iwait_b0", 32'(iwait), 32'h1);
        step();
        chk("s1.dwait_b1", 32'(dwait), 32'h1);
        chk("s1.iwait_b1", 32'(iwait), 32'h1);
        ramstate = 2'd2;
        #1;
        chk("s1.dwait_acc", 32'(dwait), 32'h0);
        chk("s1.iwait_acc", 32'(iwait), 32'h1);
        chk("s1.dload_acc", dload, 32'h5555);
        idle_inputs();
        step();

        for (int i = 0; i < 9; i++) begin
            iREN = tv[i].ien; dREN = tv[i].den; dWEN = tv[i].dwen;
            iaddr = tv[i].ia; daddr = tv[i].da; dstore = tv[i].ds;
            ramload = tv[i].rl; ramstate = tv[i].rs;
            #1;
            chk($sformatf("v%0d.grant", i), 32'(grant), 32'(tv[i].g));
            chk($sformatf("v%0d.iwait", i), 32'(iwait), 32'(tv[i].iw));
            chk($sformatf("v%0d.dwait", i), 32'(dwait), 32'(tv[i].dw));
            chk($sformatf("v%0d.ren", i), 32'(ramREN), 32'(tv[i].ren));
            chk($sformatf("v%0d.wen", i), 32'(ramWEN), 32'(tv[i].wen));
            chk($sformatf("v%0d.err", i), 32'(ram_err), 32'(tv[i].err));
            chk($sformatf("v%0d.addr", i), ramaddr, tv[i].ra);
            if (^tv[i].rst_ !== 1'bx)
                chk($sformatf("v%0d.store", i), ramstore, tv[i].rst_);
            chk($sformatf("v%0d.iload", i), iload, tv[i].il);
            chk($sformatf("v%0d.dload", i), dload, tv[i].dl);
            step();
        end

        // two-word write-back cannot be split by the icache
        idle_inputs();
        iREN = 1; iaddr = 32'h300;
        dWEN = 1; daddr = 32'h40; dstore = 32'hDEADBEEF;
        step();
        ramstate = 2'd2;
        #1;
        chk("wb0.grant", 32'(grant), 32'h2);
        chk("wb0.wen", 32'(ramWEN), 32'h1);
        chk("wb0.addr", ramaddr, 32'h40);
        chk("wb0.store", ramstore, 32'hDEADBEEF);
        chk("wb0.dwait", 32'(dwait), 32'h0);
        step();
        daddr = 32'h44; dstore = 32'hCAFEF00D;
        #1;
        chk("wb1.grant", 32'(grant), 32'h2);
        chk("wb1.addr", ramaddr, 32'h44);
        chk("wb1.store", ramstore, 32'hCAFEF00D);
        step();
        dWEN = 0; ramstate = 2'd0;
        #1;
        chk("wb.rel_grant", 32'(grant), 32'h2);
        step();
        chk("wb.ho_grant", 32'(grant), 32'h1);
        chk("wb.ho_ren", 32'(ramREN), 32'h1);
        chk("wb.ho_addr", ramaddr, 32'h300);
        iREN = 0;
        step();

        // icache waits behind a long dcache ownership
        idle_inputs();
        iREN = 1; iaddr = 32'h500; dREN = 1; daddr = 32'h600;
        ramstate = 2'd1;
        step();
        for (int i = 0; i < 10; i++) step();
        chk("st.grant", 32'(grant), 32'h2);
        chk("st.cnt_sat", 32'(dut.starve_cnt), 32'h8);
        dREN = 0;
        step();
        chk("st.igrant", 32'(grant), 32'h1);
        chk("st.cnt_clr", 32'(dut.starve_cnt), 32'h0);
        iREN = 0;
        step();

        // RAM error during an icache fetch
        idle_inputs();
        nRST = 1;
        #1;
        nRST = 0;
        iREN = 1; iaddr = 32'h100;
        step();
        ramstate = 2'd3; ramload = 32'h5A5A;
        #1;
        chk("er.iwait", 32'(iwait), 32'h0);
        chk("er.iload", iload, 32'h0);
        chk("er.addr", ramaddr, 32'h100);
        chk("er.err_pre", 32'(ram_err), 32'h0);
        step();
        ramstate = 2'd2; ramload = 32'h77;
        #1;
        chk("er.err_set", 32'(ram_err), 32'h1);
        chk("er.iload_ok", iload, 32'h77);
        step();
        chk("er.err_hold", 32'(ram_err), 32'h1);
        iREN = 0;
        step();

        // reset in the middle of a dcache write
        idle_inputs();
        dWEN = 1; daddr = 32'h80; dstore = 32'h1; ramstate = 2'd1;
        step();
        chk("ar.wen_pre", 32'(ramWEN), 32'h1);
        #2;
        nRST = 1;
        #1;
        chk("ar.wen_async", 32'(ramWEN), 32'h0);
        chk("ar.grant_async", 32'(grant), 32'h0);
        #1;
        nRST = 0;
        dWEN = 0; iREN = 1; iaddr = 32'h700;
        step();
        chk("ar.igrant", 32'(grant), 32'h1);
        iREN = 0;
        step();

        // read and write together: write wins
        idle_inputs();
        dREN = 1; dWEN = 1; daddr = 32'h90; dstore = 32'h42;
        ramstate = 2'd1;
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rw%0d.wen", i), 32'(ramWEN), 32'h1);
            chk($sformatf("rw%0d.ren", i), 32'(ramREN), 32'h0);
            step();
        end
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port RAM arbiter between the instruction cache and the data cache. Registered grant FSM gives one requester exclusive RAM ownership for the full duration of its request, so a dcache two-word block write-back or allocate cannot be split. Data-side priority, with an icache starvation guard. Sits between the icache/dcache pair and the RAM model, in the slot of the combinational memory controller.

## Interface
Parameters:
- STARVE_LIMIT, 8: consecutive ungranted icache-request cycles before icache wins the next arbitration.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous reset, active-high (nRST=1 resets); name kept for codebase consistency.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address.
- dstore  in  32  dcache write data.
- iwait  out  1  icache stall.
- dwait  out  1  dcache stall.
- iload  out  32  icache read data.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- grant  out  2  current owner: 00 none, 01 icache, 10 dcache.
- ram_err  out  1  sticky; set on any ERROR, cleared only by reset.

## Operation
- States: IDLE, IGNT, DGNT (registered, 2 bits).
- dreq = dREN | dWEN. If both are asserted, dWEN wins and dREN is ignored.
- Arbitration point: any edge in IDLE, or the edge where the owner's request is low (release).
  - At an arbitration point, evaluate: dreq & !(iREN & starved) -> DGNT; else iREN -> IGNT; else IDLE.
  - starved = (starve_cnt == STARVE_LIMIT).
- Owner holds the grant while its request stays high. Address and read/write may change between words with no re-arbitration.
- RAM outputs, driven combinationally from the registered state:
  - IGNT: ramREN=1, ramWEN=0, ramaddr=iaddr.
  - DGNT: ramREN=dREN&!dWEN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - IDLE: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Waits:
  - Owner's wait = !(ramstate==ACCESS || ramstate==ERROR).
  - Non-owner's wait = 1.
- Loads: iload = dload = ramload, gated to 0 when the port is not the owner.
- ERROR ramstate completes the word: wait drops, load data is 0, and ram_err is set.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, each cycle iREN=1 and state!=IGNT.
  - Clears when state becomes IGNT or when iREN=0.

## Timing
- Reset values: state IDLE, grant 00, iwait=dwait=1, ramREN=ramWEN=0, ramaddr=ramstore=0, iload=dload=0, ram_err=0, starve_cnt=0.
- Grant latency: a request seen in IDLE at edge n gives RAM enables high in cycle n+1. First completion is no earlier than cycle n+1, when ramstate==ACCESS.
- Handover: owner drops its request in cycle k. At edge k the other pending requester is granted directly, with no IDLE bubble, and its enables are high in cycle k+1.
- Simultaneous request and release: the arbitration rule applies unchanged. The releasing requester may re-win if it requests again and has priority.
- Reset mid-transfer drops the enables immediately (asynchronous). The in-flight word is abandoned.
- Request dropped before ACCESS: release still occurs at that edge. The RAM sees the enables fall; no completion is reported.

## Structure
- Add to cpu_types_pkg:
  - ramstate_t enum (FREE/BUSY/ACCESS/ERROR).
  - word_t (32 bits).
  - arb_state_t enum (IDLE/IGNT/DGNT).
- One sub-module, sat_counter (width from $clog2(STARVE_LIMIT+1), inc/clr inputs), used for starve_cnt.
- Everything else is a single always_ff for state and ram_err plus one always_comb for outputs.

## Test plan
- Reset with nRST=1 while iREN=dREN=1 -> all outputs at reset values. Release, then RAM returns ACCESS after 2 BUSY cycles -> grant=10 at the first edge; dwait low only in the ACCESS cycle; iwait=1 throughout.
- dcache two-word write-back (dWEN high 2 words, daddr 0x40 then 0x44, dstore 0xDEADBEEF/0xCAFEF00D) with iREN high -> grant stays 10 across both words; ramstore matches each word; grant=01 at the edge dWEN falls.
- Continuous dREN bursts re-requested each release, with iREN held high -> icache granted no later than the arbitration point after starve_cnt reaches 8; starve_cnt reads 0 the cycle after IGNT.
- ramstate=ERROR during an icache fetch at 0x100 -> iwait=0, iload=0 that cycle; ram_err=1 and stays 1 through later ACCESS cycles.
- nRST pulse in the middle of a DGNT word -> ramWEN falls asynchronously; after release with only iREN=1, grant=01 one edge later.
- dREN=dWEN=1 simultaneously -> ramWEN=1, ramREN=0 for the whole grant.
